// File: rtl/axi_if_glwe_axi_ram_responder.sv
// AXI4 responder backing the GLWE ciphertext-area bus with an on-chip dual-port RAM.
// Independent read and write channels, one outstanding INCR burst each, 1-cycle RAM read latency.
// Optional build macro: AXI_IF_GLWE_RAM_RESP_PAGE_CHECK_EN -- a burst whose byte range crosses a
// PAGE_BYTES boundary is treated like an illegal burst (SLVERR, writes dropped, read data zero).
module axi_if_glwe_axi_ram_responder #(
  parameter int unsigned AXI4_DATA_W = 512,
  parameter int unsigned AXI4_ID_W   = 1,
  parameter int unsigned AXI4_ADD_W  = 64,
  parameter int unsigned RAM_DEPTH   = 1024,
  parameter int unsigned PAGE_BYTES  = 4096
) (
  input  logic                   clk,
  input  logic                   s_rst,
  // AR channel
  input  logic [AXI4_ID_W-1:0]   s_arid,
  input  logic [AXI4_ADD_W-1:0]  s_araddr,
  input  logic [7:0]             s_arlen,
  input  logic [2:0]             s_arsize,
  input  logic [1:0]             s_arburst,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  // R channel
  output logic [AXI4_ID_W-1:0]   s_rid,
  output logic [AXI4_DATA_W-1:0] s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rlast,
  output logic                   s_rvalid,
  input  logic                   s_rready,
  // AW channel
  input  logic [AXI4_ID_W-1:0]   s_awid,
  input  logic [AXI4_ADD_W-1:0]  s_awaddr,
  input  logic [7:0]             s_awlen,
  input  logic [2:0]             s_awsize,
  input  logic [1:0]             s_awburst,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  // W channel
  input  logic [AXI4_DATA_W-1:0]   s_wdata,
  input  logic [AXI4_DATA_W/8-1:0] s_wstrb,
  input  logic                     s_wlast,
  input  logic                     s_wvalid,
  output logic                     s_wready,
  // B channel
  output logic [AXI4_ID_W-1:0]   s_bid,
  output logic [1:0]             s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready
);

  localparam int unsigned AXI4_STRB_W       = AXI4_DATA_W / 8;
  localparam int unsigned AXI4_DATA_BYTES_W = $clog2(AXI4_DATA_W / 8);
  localparam int unsigned RAM_ADD_W         = $clog2(RAM_DEPTH);
  localparam int unsigned PAGE_W            = $clog2(PAGE_BYTES);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // True when a burst starting at page offset off with len+1 full-width beats runs past the page end
  function automatic logic page_cross(input logic [PAGE_W-1:0] off, input logic [7:0] len);
    logic [31:0] span;
    span = 32'(off) + (32'(len) + 32'd1) * 32'(AXI4_STRB_W);
    return span > 32'(PAGE_BYTES);
  endfunction

  logic [AXI4_DATA_W-1:0] mem [RAM_DEPTH];

  r_state_t             r_state, r_state_d;
  logic [RAM_ADD_W-1:0] r_addr;
  logic [7:0]           r_len;
  logic [8:0]           r_issued;
  logic                 r_err;
  logic                 r_issue_c;
  logic                 ar_bad_c;

  w_state_t             w_state, w_state_d;
  logic [RAM_ADD_W-1:0] w_addr;
  logic [7:0]           w_len;
  logic [7:0]           w_cnt;
  logic                 w_err;
  logic                 w_lerr;
  logic                 w_beat_hs_c;
  logic                 w_last_beat_c;
  logic                 w_lmis_c;
  logic                 aw_bad_c;
  logic                 mem_we_c;

  // Address bits above the RAM window alias and are intentionally ignored
  logic unused_c;
  assign unused_c = ^{s_araddr, s_awaddr};

  // Burst legality of the request currently presented on AR / AW
  always_comb begin
    ar_bad_c = (s_arburst != BURST_INCR) || (s_arsize != 3'(AXI4_DATA_BYTES_W));
    aw_bad_c = (s_awburst != BURST_INCR) || (s_awsize != 3'(AXI4_DATA_BYTES_W));
`ifdef AXI_IF_GLWE_RAM_RESP_PAGE_CHECK_EN
    ar_bad_c = ar_bad_c || page_cross(s_araddr[PAGE_W-1:0], s_arlen);
    aw_bad_c = aw_bad_c || page_cross(s_awaddr[PAGE_W-1:0], s_awlen);
`endif
  end

  // Read FSM next state and RAM read issue decision
  always_comb begin
    r_state_d = r_state;
    r_issue_c = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (s_arvalid && s_arready) r_state_d = R_BURST;
      end
      R_BURST: begin
        r_issue_c = (r_issued <= {1'b0, r_len}) && (!s_rvalid || s_rready);
        if (s_rvalid && s_rready && s_rlast) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read state, burst context and registered R channel (RAM read lands directly in s_rdata)
  always_ff @(posedge clk) begin
    if (s_rst) begin
      r_state   <= R_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rlast   <= 1'b0;
      s_rresp   <= RESP_OKAY;
      s_rid     <= '0;
      s_rdata   <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_issued  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= r_state_d;
      s_arready <= (r_state_d == R_IDLE);
      if (s_arvalid && s_arready) begin
        s_rid    <= s_arid;
        r_addr   <= s_araddr[AXI4_DATA_BYTES_W +: RAM_ADD_W];
        r_len    <= s_arlen;
        r_err    <= ar_bad_c;
        r_issued <= '0;
      end
      if (r_issue_c) begin
        s_rvalid <= 1'b1;
        s_rdata  <= r_err ? '0 : mem[r_addr];
        s_rresp  <= r_err ? RESP_SLVERR : RESP_OKAY;
        s_rlast  <= (r_issued == {1'b0, r_len});
        r_addr   <= r_addr + RAM_ADD_W'(1);
        r_issued <= r_issued + 9'd1;
      end else if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0;
        s_rlast  <= 1'b0;
      end
    end
  end

  // Write FSM next state and beat qualification
  always_comb begin
    w_state_d     = w_state;
    w_beat_hs_c   = 1'b0;
    w_last_beat_c = 1'b0;
    w_lmis_c      = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (s_awvalid && s_awready) w_state_d = W_DATA;
      end
      W_DATA: begin
        w_beat_hs_c   = s_wvalid && s_wready;
        w_last_beat_c = (w_cnt == w_len);
        w_lmis_c      = (s_wlast != w_last_beat_c);
        if (w_beat_hs_c && w_last_beat_c) w_state_d = W_RESP;
      end
      W_RESP: begin
        if (s_bvalid && s_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign mem_we_c = w_beat_hs_c && !w_err && !s_rst;

  // Write state, burst context and registered AW/W/B handshake outputs
  always_ff @(posedge clk) begin
    if (s_rst) begin
      w_state   <= W_IDLE;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      s_bid     <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_err     <= 1'b0;
      w_lerr    <= 1'b0;
    end else begin
      w_state   <= w_state_d;
      s_awready <= (w_state_d == W_IDLE);
      s_wready  <= (w_state_d == W_DATA);
      s_bvalid  <= (w_state_d == W_RESP);
      if (s_awvalid && s_awready) begin
        s_bid  <= s_awid;
        w_addr <= s_awaddr[AXI4_DATA_BYTES_W +: RAM_ADD_W];
        w_len  <= s_awlen;
        w_err  <= aw_bad_c;
        w_cnt  <= '0;
        w_lerr <= 1'b0;
      end
      if (w_beat_hs_c) begin
        w_addr <= w_addr + RAM_ADD_W'(1);
        w_cnt  <= w_cnt + 8'd1;
        if (w_lmis_c) w_lerr <= 1'b1;
        if (w_last_beat_c) s_bresp <= (w_err || w_lerr || w_lmis_c) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // RAM write port with byte enables; reads in the same cycle see the old word
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < int'(AXI4_STRB_W); b++) begin
        if (s_wstrb[b]) mem[w_addr][b*8 +: 8] <= s_wdata[b*8 +: 8];
      end
    end
  end

endmodule
